booth_divider: RTL and testbench

Sequential signed restoring divider: the inverse datapath to the team's sequential Booth multiplier. It accepts an N-bit signed dividend and divisor on a `start` pulse, performs one restoring shift/subtract step per two clocks using an (N+1)-bit `carry_lookahead_adder`, and presents a truncated-toward-zero quotient and remainder with a one-cycle `done` strobe. It shares the multiplier's start/done handshake, so the two blocks are interchangeable behind the same arithmetic-unit sequencer.

---
 rtl/booth_divider.sv | 183 ++++++++++++++++++
 tb/tb_booth_divider.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/booth_divider.sv
// booth_divider
//   Sequential signed restoring divider sharing the start/done handshake of
//   the sequential Booth multiplier. Each restoring step takes two clocks:
//   a shift/subtract cycle (SHIFT_SUB) and a test/set cycle (TEST_SET).
//   Results are truncated toward zero.
//
//   Ports
//     clock          rising-edge clock
//     reset          asynchronous reset, active low
//     start          request, sampled only in IDLE
//     dividend       signed dividend, sampled in INITIALIZE
//     divisor        signed divisor, sampled in INITIALIZE
//     quotient       signed quotient, nonzero only while done = 1
//     remainder      signed remainder, nonzero only while done = 1
//     done           one-cycle completion strobe
//     divide_by_zero high with done when the divisor was zero
//
//   state      | meaning
//   IDLE       | waiting for start
//   INITIALIZE | latch signs and magnitudes, clear A/count
//   SHIFT_SUB  | shift {A,Q} left, T <= A_shifted - M
//   TEST_SET   | restore or accept T, set quotient bit
//   SIGN_FIX   | apply signs to quotient and remainder
//   DONE       | present results for one cycle

module carry_lookahead_adder #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic         cy;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        sum = '0;
        cy  = cin;
        for (int i = 0; i < W; i++) begin
            sum[i] = p[i] ^ cy;
            cy     = g[i] | (p[i] & cy);
        end
        cout = cy;
    end
endmodule

module booth_divider #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         done,
    output logic         divide_by_zero
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        INITIALIZE,
        SHIFT_SUB,
        TEST_SET,
        SIGN_FIX,
        DONE
    } state_t;

    state_t        state;
    logic [N:0]    acc;
    logic [N-1:0]  q_reg;
    logic [N:0]    m_reg;
    logic [N:0]    t_reg;
    logic [CW-1:0] count;
    logic          q_sign;
    logic          r_sign;
    logic          dz_flag;
    logic [N-1:0]  q_res;
    logic [N-1:0]  r_res;

    logic [N:0]    a_shifted;
    logic [N:0]    neg_m;
    logic [N:0]    diff;
    logic          unused_cout;
    logic          unused_acc_msb;

    // acc[N] is always 0 after a test step (A < M <= 2^(N-1)); the shift drops it.
    assign a_shifted      = {acc[N-1:0], q_reg[N-1]};
    assign neg_m          = ~m_reg + {{N{1'b0}}, 1'b1};
    assign unused_acc_msb = acc[N];

    carry_lookahead_adder #(.W(N + 1)) u_adder (
        .a   (a_shifted),
        .b   (neg_m),
        .cin (1'b0),
        .sum (diff),
        .cout(unused_cout)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            acc     <= '0;
            q_reg   <= '0;
            m_reg   <= '0;
            t_reg   <= '0;
            count   <= '0;
            q_sign  <= 1'b0;
            r_sign  <= 1'b0;
            dz_flag <= 1'b0;
            q_res   <= '0;
            r_res   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= INITIALIZE;
                end
                INITIALIZE: begin
                    q_sign <= dividend[N-1] ^ divisor[N-1];
                    r_sign <= dividend[N-1];
                    // -(-2^(N-1)) wraps to 2^(N-1), which is the correct unsigned magnitude.
                    q_reg  <= dividend[N-1] ? -dividend : dividend;
                    m_reg  <= {1'b0, (divisor[N-1] ? -divisor : divisor)};
                    acc    <= '0;
                    t_reg  <= '0;
                    count  <= '0;
                    if (divisor == '0) begin
                        dz_flag <= 1'b1;
                        q_res   <= '1;
                        r_res   <= dividend;
                        state   <= DONE;
                    end else begin
                        dz_flag <= 1'b0;
                        state   <= SHIFT_SUB;
                    end
                end
                SHIFT_SUB: begin
                    acc   <= a_shifted;
                    q_reg <= {q_reg[N-2:0], 1'b0};
                    t_reg <= diff;
                    state <= TEST_SET;
                end
                TEST_SET: begin
                    if (t_reg[N]) begin
                        q_reg[0] <= 1'b0;
                    end else begin
                        acc      <= t_reg;
                        q_reg[0] <= 1'b1;
                    end
                    if (count == COUNT_LAST) begin
                        state <= SIGN_FIX;
                    end else begin
                        count <= count + 1'b1;
                        state <= SHIFT_SUB;
                    end
                end
                SIGN_FIX: begin
                    q_res <= q_sign ? -q_reg : q_reg;
                    r_res <= r_sign ? -acc[N-1:0] : acc[N-1:0];
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign done           = (state == DONE);
    assign quotient       = done ? q_res : '0;
    assign remainder      = done ? r_res : '0;
    assign divide_by_zero = done & dz_flag;
endmodule

// File: tb/tb_booth_divider.sv
module tb_booth_divider;
    localparam int N = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         done;
    logic         divide_by_zero;

    int tests = 0;
    int fails = 0;

    booth_divider #(.N(N)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .dividend      (dividend),
        .divisor       (divisor),
        .quotient      (quotient),
        .remainder     (remainder),
        .done          (done),
        .divide_by_zero(divide_by_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: signed truncating division with the zero-divisor and
    // most-negative / -1 rules layered on top.
    task automatic model(input int a, input int b,
                         output logic [N-1:0] q, output logic [N-1:0] r, output logic dz);
        int qi, ri;
        if (b == 0) begin
            q = '1; r = N'(a); dz = 1'b1;
        end else if (a == -(2 ** (N - 1)) && b == -1) begin
            q = N'(a); r = '0; dz = 1'b0;
        end else begin
            qi = a / b; ri = a % b;
            q = N'(qi); r = N'(ri); dz = 1'b0;
        end
    endtask

    task automatic run_op(input int a, input int b, input bit disturb);
        logic [N-1:0] eq, er;
        logic         edz;
        int           edges;
        int           exp_lat;
        bit           before_zero;
        model(a, b, eq, er, edz);
        exp_lat = (b == 0) ? 1 : 2 * N + 2;
        @(negedge clock);
        dividend = N'(a); divisor = N'(b); start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        edges = 0;
        before_zero = 1'b1;
        while (done !== 1'b1 && edges < 40) begin
            before_zero = (quotient === '0 && remainder === '0 && divide_by_zero === 1'b0);
            if (disturb && edges == 3) begin
                dividend = N'($urandom); divisor = N'($urandom); start = 1'b1;
            end
            if (disturb && edges == 4) start = 1'b0;
            @(posedge clock); edges++; @(negedge clock);
        end
        chk($sformatf("done_seen %0d/%0d", a, b), done, 1);
        chk($sformatf("latency %0d/%0d", a, b), edges, exp_lat);
        chk($sformatf("quotient %0d/%0d", a, b), quotient, eq);
        chk($sformatf("remainder %0d/%0d", a, b), remainder, er);
        chk($sformatf("dbz %0d/%0d", a, b), divide_by_zero, edz);
        chk($sformatf("zero_before %0d/%0d", a, b), before_zero, 1);
        @(posedge clock); @(negedge clock);
        chk($sformatf("done_after %0d/%0d", a, b), done, 0);
        chk($sformatf("zero_after %0d/%0d", a, b), {quotient, remainder}, 0);
    endtask

    initial begin
        int cnt;
        int done_seen;
        logic [N-1:0] ra, rb;

        repeat (2) @(negedge clock);
        chk("reset_done", done, 0);
        chk("reset_q", quotient, 0);
        chk("reset_r", remainder, 0);
        chk("reset_dbz", divide_by_zero, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("idle_done", done, 0);

        run_op(7, 2, 0);
        run_op(-7, 2, 0);
        run_op(7, -2, 0);
        run_op(-7, -2, 0);
        run_op(0, 5, 0);
        run_op(-8, -1, 0);
        run_op(-8, 1, 0);
        run_op(-8, 3, 0);
        run_op(7, 7, 0);
        run_op(3, 7, 0);
        run_op(5, 0, 0);
        run_op(7, 2, 1);
        run_op(-5, 3, 1);

        // start held high: results every 2N+4 cycles
        @(negedge clock);
        dividend = N'(6); divisor = N'(4); start = 1'b1;
        cnt = 0;
        while (done !== 1'b1 && cnt < 40) begin
            @(posedge clock); cnt++; @(negedge clock);
        end
        chk("b2b_first_done", done, 1);
        chk("b2b_first_q", quotient, 1);
        cnt = 0;
        do begin
            @(posedge clock); cnt++; @(negedge clock);
        end while (done !== 1'b1 && cnt < 40);
        start = 1'b0;
        chk("b2b_period", cnt, 2 * N + 4);
        chk("b2b_second_r", remainder, 2);
        repeat (2) @(negedge clock);

        // async reset while results are presented
        @(negedge clock);
        dividend = N'(7); divisor = N'(2); start = 1'b1;
        @(negedge clock); start = 1'b0;
        cnt = 0;
        while (done !== 1'b1 && cnt < 40) begin
            @(posedge clock); cnt++; @(negedge clock);
        end
        chk("rst_pre_done", done, 1);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_done", done, 0);
        chk("rst_async_q", quotient, 0);
        chk("rst_async_r", remainder, 0);
        @(negedge clock); reset = 1'b1;
        repeat (2) @(negedge clock);

        // reset at iteration 2 aborts with no done pulse
        dividend = N'(5); divisor = N'(3); start = 1'b1;
        @(posedge clock); @(negedge clock); start = 1'b0;
        repeat (5) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("abort_done", done, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        done_seen = 0;
        repeat (20) begin
            @(negedge clock);
            if (done === 1'b1) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        run_op(6, 4, 0);

        for (int k = 0; k < 30; k++) begin
            ra = N'($urandom);
            rb = N'($urandom_range(0, 15));
            run_op(int'($signed(ra)), int'($signed(rb)), k[0]);
        end

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                ra = N'(i); rb = N'(j);
                run_op(int'($signed(ra)), int'($signed(rb)), 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
